// File: rtl/lsu_bus_master.sv
// Load/store bus master: registered access FSM between the execute stage and the system bus.
// Handles byte enables, sub-word store replication, load extension, grant handshake and error reporting.
module lsu_bus_master #(
  parameter int                ADDR_W   = 32,
  parameter int                NUM_CE   = 8,
  parameter logic [NUM_CE-1:0] GNT_MASK = NUM_CE'(8'h07),
  parameter int                TIMEOUT  = 16
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_REQ,
  input  logic              i_WE,
  input  logic [ADDR_W-1:0] i_ADDR,
  input  logic [31:0]       i_WDATA,
  input  logic [1:0]        i_SIZE,
  input  logic              i_ULOAD,
  output logic [31:0]       o_RDATA,
  output logic              o_STALL,
  output logic              o_ERR,
  output logic              o_BUS_REQ,
  input  logic              i_BUS_GNT,
  output logic [ADDR_W-1:0] o_BUS_ADDR,
  output logic [31:0]       o_BUS_WDATA,
  output logic              o_BUS_WE,
  output logic              o_BUS_RE,
  output logic [3:0]        o_BUS_BE,
  output logic [NUM_CE-1:0] o_BUS_CE,
  input  logic [31:0]       i_BUS_RDATA
);

  localparam int CE_BITS = $clog2(NUM_CE);
  localparam int CNT_W   = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERR
  } state_t;

  state_t              r_state;
  logic [1:0]          r_lane;
  logic [1:0]          r_size;
  logic                r_uload;
  logic                r_gnt_rgn;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_bus_req;
  logic                r_bus_we;
  logic                r_bus_re;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [31:0]         r_bus_wdata;
  logic [3:0]          r_bus_be;
  logic [NUM_CE-1:0]   r_bus_ce;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic [1:0]          w_size;
  logic                w_misaligned;
  logic [CE_BITS-1:0]  w_region;
  logic [NUM_CE-1:0]   w_ce;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_shifted;
  logic [31:0]         w_load;
  logic                w_complete;
  logic                w_timeout;

  // Request decode: size code 11 is folded into word before anything else looks at it.
  always_comb begin
    w_size       = (i_SIZE == 2'b11) ? SZ_W : i_SIZE;
    w_region     = i_ADDR[ADDR_W-1 -: CE_BITS];
    w_ce         = {{(NUM_CE-1){1'b0}}, 1'b1} << w_region;
    w_misaligned = ((w_size == SZ_H) && i_ADDR[0]) ||
                   ((w_size == SZ_W) && (i_ADDR[1:0] != 2'b00));
    case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << i_ADDR[1:0];
        w_wdata = {4{i_WDATA[7:0]}};
      end
      SZ_H: begin
        w_be    = 4'b0011 << i_ADDR[1:0];
        w_wdata = {2{i_WDATA[15:0]}};
      end
      default: begin
        w_be    = 4'hF;
        w_wdata = i_WDATA;
      end
    endcase
  end

  // Load return path and completion conditions for the current ACCESS cycle.
  always_comb begin
    w_shifted = i_BUS_RDATA >> {r_lane, 3'b000};
    case (r_size)
      SZ_B:    w_load = r_uload ? {24'h0, w_shifted[7:0]}
                                : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    w_load = r_uload ? {16'h0, w_shifted[15:0]}
                                : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
    w_complete = r_gnt_rgn ? i_BUS_GNT : 1'b1;
    w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state     <= IDLE;
      r_lane      <= 2'b00;
      r_size      <= SZ_W;
      r_uload     <= 1'b0;
      r_gnt_rgn   <= 1'b0;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_re    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_bus_ce    <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_REQ) begin
            if (w_misaligned) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else begin
              r_state     <= ACCESS;
              r_lane      <= i_ADDR[1:0];
              r_size      <= w_size;
              r_uload     <= i_ULOAD;
              r_gnt_rgn   <= GNT_MASK[w_region];
              r_cnt       <= '0;
              r_bus_req   <= 1'b1;
              r_bus_we    <= i_WE;
              r_bus_re    <= ~i_WE;
              r_bus_addr  <= {i_ADDR[ADDR_W-1:2], 2'b00};
              r_bus_wdata <= w_wdata;
              r_bus_be    <= w_be;
              r_bus_ce    <= w_ce;
            end
          end
        end
        ACCESS: begin
          // A grant arriving on the timeout cycle wins over the timeout.
          if (w_complete || w_timeout) begin
            r_state     <= w_complete ? DONE : ERR;
            r_err       <= ~w_complete;
            r_rdata     <= (w_complete && !r_bus_we) ? w_load : 32'h0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_re    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
            r_bus_ce    <= '0;
          end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_STALL     = ~i_RST & (((r_state == IDLE) & i_REQ) | (r_state == ACCESS));
  assign o_ERR       = r_err;
  assign o_RDATA     = r_rdata;
  assign o_BUS_REQ   = r_bus_req;
  assign o_BUS_WE    = r_bus_we;
  assign o_BUS_RE    = r_bus_re;
  assign o_BUS_ADDR  = r_bus_addr;
  assign o_BUS_WDATA = r_bus_wdata;
  assign o_BUS_BE    = r_bus_be;
  assign o_BUS_CE    = r_bus_ce;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: a transaction-level model builds the expected per-cycle
// output timeline from the access rules, and one negedge process compares the DUT against it.
module tb_lsu_bus_master;

  localparam logic [7:0] TB_GNT_MASK = 8'h07;
  localparam int         TB_TIMEOUT  = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        uload;
  logic [31:0] rdata;
  logic        stall;
  logic        err;
  logic        busReq;
  logic        busGnt;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic        busWe;
  logic        busRe;
  logic [3:0]  busBe;
  logic [7:0]  busCe;
  logic [31:0] busRdata;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic        stall;
    logic        err;
    logic        busReq;
    logic        busWe;
    logic        busRe;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic [3:0]  busBe;
    logic [7:0]  busCe;
    logic        chkRdata;
    logic [31:0] rdata;
  } expT;

  expT expQ[$];
  expT cur;

  lsu_bus_master #(
    .ADDR_W   (32),
    .NUM_CE   (8),
    .GNT_MASK (TB_GNT_MASK),
    .TIMEOUT  (TB_TIMEOUT)
  ) dut (
    .i_CLK       (clock),
    .i_RST       (reset),
    .i_REQ       (req),
    .i_WE        (we),
    .i_ADDR      (addr),
    .i_WDATA     (wdata),
    .i_SIZE      (size),
    .i_ULOAD     (uload),
    .o_RDATA     (rdata),
    .o_STALL     (stall),
    .o_ERR       (err),
    .o_BUS_REQ   (busReq),
    .i_BUS_GNT   (busGnt),
    .o_BUS_ADDR  (busAddr),
    .o_BUS_WDATA (busWdata),
    .o_BUS_WE    (busWe),
    .o_BUS_RE    (busRe),
    .o_BUS_BE    (busBe),
    .o_BUS_CE    (busCe),
    .i_BUS_RDATA (busRdata)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int sizeBytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] modelBe(input int bytes, input int ofs);
    logic [3:0] m;
    m = 4'((1 << bytes) - 1);
    return m << ofs;
  endfunction

  // Each byte lane carries the store byte whose index matches the lane modulo the access width.
  function automatic logic [31:0] modelWdata(input logic [31:0] d, input int bytes);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % bytes) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] rd, input int bytes, input int ofs,
                                            input logic ul);
    longint unsigned v;
    longint unsigned mask;
    v    = 64'(rd) >> (8 * ofs);
    mask = (64'd1 << (8 * bytes)) - 1;
    v    = v & mask;
    if (!ul && v[8*bytes-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Builds the expected timeline of one core access, then drives it cycle by cycle.
  task automatic applyStimulus(input logic isWe, input logic [31:0] a, input logic [31:0] wd,
                               input logic [1:0] sz, input logic ul, input logic [31:0] rd,
                               input int gntAt, output int stallCnt, output int errCnt,
                               output int reqCnt, output logic [31:0] capAddr,
                               output logic [31:0] capWdata, output logic [3:0] capBe,
                               output logic [7:0] capCe);
    int   bytes  = sizeBytes(sz);
    int   ofs    = int'(a[1:0]);
    int   region = int'(a[31:29]);
    bit   gntRgn = TB_GNT_MASK[region];
    bit   mis    = (ofs % bytes) != 0;
    int   nAcc   = 0;
    bit   toErr  = 0;
    int   total;
    expT  e;

    if (!mis) begin
      if (!gntRgn) nAcc = 1;
      else if (gntAt >= 1 && (TB_TIMEOUT == 0 || gntAt <= TB_TIMEOUT)) nAcc = gntAt;
      else begin
        nAcc  = TB_TIMEOUT;
        toErr = 1;
      end
    end
    total = mis ? 3 : nAcc + 3;

    @(posedge clock);
    #1;
    e = '0;
    e.stall = 1'b1;
    expQ.push_back(e);
    if (mis) begin
      e = '0;
      e.err = 1'b1;
      expQ.push_back(e);
    end else begin
      for (int k = 1; k <= nAcc; k++) begin
        e          = '0;
        e.stall    = 1'b1;
        e.busReq   = 1'b1;
        e.busWe    = isWe;
        e.busRe    = ~isWe;
        e.busAddr  = a & 32'hFFFF_FFFC;
        e.busWdata = isWe ? modelWdata(wd, bytes) : modelWdata(wd, bytes);
        e.busBe    = modelBe(bytes, ofs);
        e.busCe    = 8'(1 << region);
        expQ.push_back(e);
      end
      e          = '0;
      e.err      = toErr;
      e.chkRdata = 1'b1;
      e.rdata    = (toErr || isWe) ? 32'h0 : modelLoad(rd, bytes, ofs, ul);
      expQ.push_back(e);
    end
    e = '0;
    expQ.push_back(e);

    we       = isWe;
    addr     = a;
    wdata    = wd;
    size     = sz;
    uload    = ul;
    busRdata = rd;
    stallCnt = 0;
    errCnt   = 0;
    reqCnt   = 0;
    capAddr  = '0;
    capWdata = '0;
    capBe    = '0;
    capCe    = '0;
    for (int c = 0; c < total; c++) begin
      req    = (c < total - 1);
      busGnt = gntRgn && (gntAt > 0) && (c == gntAt);
      #1;
      stallCnt += int'(stall);
      errCnt   += int'(err);
      reqCnt   += int'(busReq);
      if (c == 1) begin
        capAddr  = busAddr;
        capWdata = busWdata;
        capBe    = busBe;
        capCe    = busCe;
      end
      if (c < total - 1) begin
        @(posedge clock);
        #1;
      end
    end
    busGnt = 1'b0;
  endtask

  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      cur = expQ.pop_front();
      checkOutput("o_STALL",     32'(stall),    32'(cur.stall));
      checkOutput("o_ERR",       32'(err),      32'(cur.err));
      checkOutput("o_BUS_REQ",   32'(busReq),   32'(cur.busReq));
      checkOutput("o_BUS_WE",    32'(busWe),    32'(cur.busWe));
      checkOutput("o_BUS_RE",    32'(busRe),    32'(cur.busRe));
      checkOutput("o_BUS_ADDR",  busAddr,       cur.busAddr);
      checkOutput("o_BUS_WDATA", busWdata,      cur.busWdata);
      checkOutput("o_BUS_BE",    32'(busBe),    32'(cur.busBe));
      checkOutput("o_BUS_CE",    32'(busCe),    32'(cur.busCe));
      if (cur.chkRdata) checkOutput("o_RDATA", rdata, cur.rdata);
    end
  end

  initial begin
    int          sc;
    int          ec;
    int          rc;
    logic [31:0] ca;
    logic [31:0] cw;
    logic [3:0]  cb;
    logic [7:0]  cc;

    reset    = 1'b1;
    req      = 1'b1;
    we       = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    size     = 2'b10;
    uload    = 1'b0;
    busGnt   = 1'b0;
    busRdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset o_STALL",   32'(stall),  32'h0);
    checkOutput("reset o_ERR",     32'(err),    32'h0);
    checkOutput("reset o_BUS_REQ", 32'(busReq), 32'h0);
    checkOutput("reset o_BUS_CE",  32'(busCe),  32'h0);
    checkOutput("reset o_BUS_ADDR", busAddr,    32'h0);
    checkOutput("reset o_RDATA",   rdata,       32'h0);
    reset = 1'b0;
    req   = 1'b0;

    // Word store to a fixed-latency region.
    applyStimulus(1'b1, 32'h6000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 0, sc, ec, rc, ca, cw, cb, cc);
    checkOutput("sw stall cycles", 32'(sc), 32'd2);
    checkOutput("sw err",          32'(ec), 32'd0);
    checkOutput("sw ce",           32'(cc), 32'h08);
    checkOutput("sw be",           32'(cb), 32'hF);
    checkOutput("sw addr",         ca,      32'h6000_0010);
    checkOutput("sw wdata",        cw,      32'hDEAD_BEEF);

    // Byte loads from a grant region, grant on the third ACCESS cycle.
    applyStimulus(1'b0, 32'h2000_0003, 32'h0, 2'b00, 1'b0, 32'h80AB_CDEF, 3, sc, ec, rc, ca, cw, cb, cc);
    checkOutput("lb stall cycles", 32'(sc), 32'd4);
    checkOutput("lb rdata",        rdata,   32'hFFFF_FF80);
    checkOutput("lb ce",           32'(cc), 32'h02);
    applyStimulus(1'b0, 32'h2000_0003, 32'h0, 2'b00, 1'b1, 32'h80AB_CDEF, 3, sc, ec, rc, ca, cw, cb, cc);
    checkOutput("lbu rdata",       rdata,   32'h0000_0080);

    // Halfword store and load in the upper half of a word.
    applyStimulus(1'b1, 32'h4000_0002, 32'h0000_1234, 2'b01, 1'b0, 32'h0, 1, sc, ec, rc, ca, cw, cb, cc);
    checkOutput("sh be",           32'(cb), 32'hC);
    checkOutput("sh wdata",        cw,      32'h1234_1234);
    checkOutput("sh rdata",        rdata,   32'h0);
    applyStimulus(1'b0, 32'h4000_0002, 32'h0, 2'b01, 1'b0, 32'h8001_0000, 2, sc, ec, rc, ca, cw, cb, cc);
    checkOutput("lh rdata",        rdata,   32'hFFFF_8001);

    // Byte store replication, size-11 word load, unsigned half load.
    applyStimulus(1'b1, 32'h6000_0001, 32'h0000_00A5, 2'b00, 1'b0, 32'h0, 0, sc, ec, rc, ca, cw, cb, cc);
    checkOutput("sb be",           32'(cb), 32'h2);
    checkOutput("sb wdata",        cw,      32'hA5A5_A5A5);
    applyStimulus(1'b0, 32'h6000_0008, 32'h0, 2'b11, 1'b0, 32'hCAFE_F00D, 0, sc, ec, rc, ca, cw, cb, cc);
    checkOutput("lw size11 rdata", rdata,   32'hCAFE_F00D);
    applyStimulus(1'b0, 32'h6000_0002, 32'h0, 2'b01, 1'b1, 32'h8001_0000, 0, sc, ec, rc, ca, cw, cb, cc);
    checkOutput("lhu rdata",       rdata,   32'h0000_8001);

    // Misaligned accesses never reach the bus.
    applyStimulus(1'b0, 32'h0000_0001, 32'h0, 2'b10, 1'b0, 32'h0, 1, sc, ec, rc, ca, cw, cb, cc);
    checkOutput("mis lw bus req",  32'(rc), 32'd0);
    checkOutput("mis lw err",      32'(ec), 32'd1);
    checkOutput("mis lw stall",    32'(sc), 32'd1);
    applyStimulus(1'b1, 32'h6000_0003, 32'h0, 2'b01, 1'b0, 32'h0, 0, sc, ec, rc, ca, cw, cb, cc);
    checkOutput("mis sh err",      32'(ec), 32'd1);
    checkOutput("mis sh bus req",  32'(rc), 32'd0);

    // Timeout with grant held low, then grant on the last allowed cycle.
    applyStimulus(1'b0, 32'h0000_0100, 32'h0, 2'b10, 1'b0, 32'h5555_5555, 0, sc, ec, rc, ca, cw, cb, cc);
    checkOutput("timeout bus req", 32'(rc), 32'd16);
    checkOutput("timeout err",     32'(ec), 32'd1);
    checkOutput("timeout rdata",   rdata,   32'h0);
    applyStimulus(1'b0, 32'h0000_0100, 32'h0, 2'b10, 1'b0, 32'h1234_5678, 16, sc, ec, rc, ca, cw, cb, cc);
    checkOutput("gnt16 err",       32'(ec), 32'd0);
    checkOutput("gnt16 bus req",   32'(rc), 32'd16);
    checkOutput("gnt16 stall",     32'(sc), 32'd17);
    checkOutput("gnt16 rdata",     rdata,   32'h1234_5678);

    // Reset on the second ACCESS cycle of a grant-region load.
    @(posedge clock);
    #1;
    we       = 1'b0;
    addr     = 32'h2000_0000;
    size     = 2'b10;
    uload    = 1'b0;
    busRdata = 32'h1111_1111;
    busGnt   = 1'b0;
    req      = 1'b1;
    #1;
    checkOutput("rst-abort idle stall", 32'(stall), 32'h1);
    @(posedge clock);
    #1;
    checkOutput("rst-abort access1 req", 32'(busReq), 32'h1);
    @(posedge clock);
    #1;
    checkOutput("rst-abort access2 req", 32'(busReq), 32'h1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rst-abort bus req",  32'(busReq), 32'h0);
    checkOutput("rst-abort bus re",   32'(busRe),  32'h0);
    checkOutput("rst-abort bus ce",   32'(busCe),  32'h0);
    checkOutput("rst-abort bus be",   32'(busBe),  32'h0);
    checkOutput("rst-abort bus addr", busAddr,     32'h0);
    checkOutput("rst-abort err",      32'(err),    32'h0);
    checkOutput("rst-abort stall",    32'(stall),  32'h0);
    reset = 1'b0;
    req   = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("post-rst err",     32'(err),    32'h0);
    checkOutput("post-rst bus req", 32'(busReq), 32'h0);
    checkOutput("post-rst stall",   32'(stall),  32'h0);
    applyStimulus(1'b1, 32'h6000_0020, 32'h0BAD_F00D, 2'b10, 1'b0, 32'h0, 0, sc, ec, rc, ca, cw, cb, cc);
    checkOutput("post-rst sw stall", 32'(sc), 32'd2);
    checkOutput("post-rst sw err",   32'(ec), 32'd0);
    checkOutput("post-rst sw wdata", cw,      32'h0BAD_F00D);

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
